// File: rtl/axi_atop_pkg.sv
// axi_atop_pkg: shared types and atop[5:4] encodings for the ATOP sequencer.
package axi_atop_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, RESP} atop_seq_state_e;

    localparam logic [1:0] ATOP_NONE     = 2'b00;
    localparam logic [1:0] ATOP_STORE    = 2'b01;
    localparam logic [1:0] ATOP_LOAD     = 2'b10;
    localparam logic [1:0] ATOP_SWAP_CMP = 2'b11;

    // Everything except an atomic store returns read data.
    function automatic logic atop_needs_r(input logic [1:0] kind);
        return (kind == ATOP_LOAD) || (kind == ATOP_SWAP_CMP);
    endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// axi_outstanding_cnt: saturating up/down counter of outstanding transactions.
module axi_outstanding_cnt #(
    parameter int unsigned CntWidth = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                inc, dec;

    assign full_o  = &cnt_q;
    assign empty_o = (cnt_q == '0);
    assign inc     = inc_i & ~full_o;
    assign dec     = dec_i & ~empty_o;
    assign cnt_d   = (inc & ~dec) ? cnt_q + 1'b1 : (dec & ~inc) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axi_atop_sequencer.sv
// axi_atop_sequencer: drains normal traffic, then lets exactly one ATOP through at a time.
// Only valid/ready are gated; payloads bypass this block.
module axi_atop_sequencer
    import axi_atop_pkg::*;
#(
    parameter int unsigned CntWidth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        slv_aw_valid_i,
    input  logic [5:0]  slv_aw_atop_i,
    output logic        slv_aw_ready_o,
    output logic        mst_aw_valid_o,
    input  logic        mst_aw_ready_i,
    input  logic        slv_w_valid_i,
    input  logic        slv_w_last_i,
    output logic        slv_w_ready_o,
    output logic        mst_w_valid_o,
    input  logic        mst_w_ready_i,
    input  logic        slv_ar_valid_i,
    output logic        slv_ar_ready_o,
    output logic        mst_ar_valid_o,
    input  logic        mst_ar_ready_i,
    input  logic        b_hs_i,
    input  logic        r_last_hs_i,
    output logic        busy_o,
    output logic [15:0] atop_cnt_o
);

    atop_seq_state_e state_q, state_d;
    logic            need_r_q, need_r_d;
    logic            w_done_q, w_done_d;
    logic            b_done_q, b_done_d;
    logic            r_done_q, r_done_d;
    logic [15:0]     atop_cnt_q, atop_cnt_d;
    logic            w_full, w_empty, r_full, r_empty;
    logic            aw_pass, w_pass, ar_pass;
    logic            aw_hs, ar_hs, w_last_hs;
    logic            atop_kind, is_atop, unused_atop;

    assign atop_kind   = (slv_aw_atop_i[5:4] != ATOP_NONE);
    assign is_atop     = slv_aw_valid_i & atop_kind;
    assign unused_atop = ^slv_aw_atop_i[3:0];
    assign aw_hs       = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs       = mst_ar_valid_o & mst_ar_ready_i;
    assign w_last_hs   = mst_w_valid_o & mst_w_ready_i & slv_w_last_i;

    axi_outstanding_cnt #(.CntWidth(CntWidth)) u_wcnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (aw_hs),
        .dec_i   (b_hs_i),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    axi_outstanding_cnt #(.CntWidth(CntWidth)) u_rcnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (ar_hs),
        .dec_i   (r_last_hs_i),
        .full_o  (r_full),
        .empty_o (r_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            need_r_q   <= 1'b0;
            w_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            r_done_q   <= 1'b0;
            atop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            need_r_q   <= need_r_d;
            w_done_q   <= w_done_d;
            b_done_q   <= b_done_d;
            r_done_q   <= r_done_d;
            atop_cnt_q <= atop_cnt_d;
        end
    end

    // Completion flags look at this cycle's events so RESP exits on the last one.
    always_comb begin
        state_d    = state_q;
        need_r_d   = need_r_q;
        w_done_d   = w_done_q | (w_last_hs & (state_q inside {ISSUE, RESP}));
        b_done_d   = b_done_q | (b_hs_i & (state_q == RESP));
        r_done_d   = r_done_q | ((r_last_hs_i | ~need_r_q) & (state_q == RESP));
        atop_cnt_d = atop_cnt_q;
        case (state_q)
            IDLE: if (is_atop) begin
                state_d  = DRAIN;
                need_r_d = atop_needs_r(slv_aw_atop_i[5:4]);
            end
            DRAIN: if (w_empty && r_empty) state_d = ISSUE;
            ISSUE: if (aw_hs) state_d = RESP;
            RESP: if (w_done_d && b_done_d && r_done_d) begin
                state_d    = is_atop ? DRAIN : IDLE;
                need_r_d   = is_atop & atop_needs_r(slv_aw_atop_i[5:4]);
                w_done_d   = 1'b0;
                b_done_d   = 1'b0;
                r_done_d   = 1'b0;
                atop_cnt_d = atop_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_pass        = ~w_full & (((state_q == IDLE) & ~atop_kind) | (state_q == ISSUE));
        ar_pass        = ~r_full & (state_q == IDLE);
        w_pass         = ~((state_q == RESP) & w_done_q);
        mst_aw_valid_o = slv_aw_valid_i & aw_pass;
        slv_aw_ready_o = mst_aw_ready_i & aw_pass;
        mst_w_valid_o  = slv_w_valid_i & w_pass;
        slv_w_ready_o  = mst_w_ready_i & w_pass;
        mst_ar_valid_o = slv_ar_valid_i & ar_pass;
        slv_ar_ready_o = mst_ar_ready_i & ar_pass;
        busy_o         = (state_q != IDLE);
        atop_cnt_o     = atop_cnt_q;
    end

    a_no_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_hs_i && w_empty) |-> (state_q == RESP));
    a_no_r_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_last_hs_i && r_empty) |-> (state_q == RESP));
    a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ISSUE && mst_aw_valid_o && !mst_aw_ready_i) |=> mst_aw_valid_o);

endmodule

// File: tb/tb_axi_atop_sequencer.sv
// tb_axi_atop_sequencer: directed stimulus with a queue-based scoreboard; dut0 uses CntWidth=4, dut1 CntWidth=2.
module tb_axi_atop_sequencer;

    typedef struct {
        string       nm;
        int          d;
        logic [6:0]  bits;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        slv_aw_valid, slv_w_valid, slv_w_last, slv_ar_valid, b_hs, r_last_hs;
    logic [5:0]  slv_aw_atop;
    logic        mst_aw_ready, mst_w_ready, mst_ar_ready;
    logic [1:0]  mst_aw_valid, slv_aw_ready, mst_w_valid, slv_w_ready, mst_ar_valid, slv_ar_ready, busy;
    logic [15:0] cnt [2];
    exp_t        sb [$];
    exp_t        e;
    logic [6:0]  act;
    int          checks = 0;
    int          errors = 0;

    localparam logic [5:0] LOAD  = 6'b100000;
    localparam logic [5:0] STORE = 6'b010000;
    localparam logic [5:0] SWAP  = 6'b110000;

    always #5 clk_i = ~clk_i;

    axi_atop_sequencer #(.CntWidth(4)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_atop_i(slv_aw_atop), .slv_aw_ready_o(slv_aw_ready[0]),
        .mst_aw_valid_o(mst_aw_valid[0]), .mst_aw_ready_i(mst_aw_ready),
        .slv_w_valid_i(slv_w_valid), .slv_w_last_i(slv_w_last), .slv_w_ready_o(slv_w_ready[0]),
        .mst_w_valid_o(mst_w_valid[0]), .mst_w_ready_i(mst_w_ready),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready[0]),
        .mst_ar_valid_o(mst_ar_valid[0]), .mst_ar_ready_i(mst_ar_ready),
        .b_hs_i(b_hs), .r_last_hs_i(r_last_hs), .busy_o(busy[0]), .atop_cnt_o(cnt[0])
    );

    axi_atop_sequencer #(.CntWidth(2)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_atop_i(slv_aw_atop), .slv_aw_ready_o(slv_aw_ready[1]),
        .mst_aw_valid_o(mst_aw_valid[1]), .mst_aw_ready_i(mst_aw_ready),
        .slv_w_valid_i(slv_w_valid), .slv_w_last_i(slv_w_last), .slv_w_ready_o(slv_w_ready[1]),
        .mst_w_valid_o(mst_w_valid[1]), .mst_w_ready_i(mst_w_ready),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready[1]),
        .mst_ar_valid_o(mst_ar_valid[1]), .mst_ar_ready_i(mst_ar_ready),
        .b_hs_i(b_hs), .r_last_hs_i(r_last_hs), .busy_o(busy[1]), .atop_cnt_o(cnt[1])
    );

    // Monitor: compares every queued expectation against the selected DUT mid-cycle.
    always @(negedge clk_i) begin
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {mst_aw_valid[e.d], slv_aw_ready[e.d], mst_w_valid[e.d], slv_w_ready[e.d],
                   mst_ar_valid[e.d], slv_ar_ready[e.d], busy[e.d]};
            checks++;
            if (act !== e.bits || cnt[e.d] !== e.cnt) begin
                errors++;
                $display("FAIL %s dut%0d: got awv/awr/wv/wr/arv/arr/busy=%b cnt=%0d, expected %b cnt=%0d",
                         e.nm, e.d, act, cnt[e.d], e.bits, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic aw, input logic [5:0] at, input logic w, input logic wl,
                       input logic ar, input logic b, input logic r);
        slv_aw_valid = aw;
        slv_aw_atop  = at;
        slv_w_valid  = w;
        slv_w_last   = wl;
        slv_ar_valid = ar;
        b_hs         = b;
        r_last_hs    = r;
    endtask

    // p = {aw pass, w pass, ar pass, busy}; valids follow from the driven inputs.
    task automatic ch(input string nm, input int d, input logic [3:0] p, input int c);
        exp_t x;
        x.nm   = nm;
        x.d    = d;
        x.bits = {slv_aw_valid & p[3], p[3], slv_w_valid & p[2], p[2], slv_ar_valid & p[1], p[1], p[0]};
        x.cnt  = 16'(c);
        sb.push_back(x);
    endtask

    task automatic st(input string nm, input int d, input logic aw, input logic [5:0] at,
                      input logic w, input logic wl, input logic ar, input logic b, input logic r,
                      input logic [3:0] p, input int c);
        drv(aw, at, w, wl, ar, b, r);
        ch(nm, d, p, c);
        tick();
    endtask

    initial begin
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        mst_ar_ready = 1'b1;
        rst_ni       = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        ch("rst_d0", 0, 4'b1110, 0);
        ch("rst_d1", 1, 4'b1110, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        // normal write: zero added latency, B three cycles later
        st("t1_aw_w",   0, 1, 0, 1, 1, 0, 0, 0, 4'b1110, 0);
        st("t1_wait0",  0, 0, 0, 0, 0, 0, 0, 0, 4'b1110, 0);
        st("t1_wait1",  0, 0, 0, 0, 0, 0, 0, 0, 4'b1110, 0);
        st("t1_b",      0, 0, 0, 0, 0, 0, 1, 0, 4'b1110, 0);
        // two writes outstanding, then a load ATOP
        st("t2_w1",          0, 1, 0,    1, 1, 0, 0, 0, 4'b1110, 0);
        st("t2_w2",          0, 1, 0,    1, 1, 0, 0, 0, 4'b1110, 0);
        st("t2_atop_idle",   0, 1, LOAD, 0, 0, 0, 0, 0, 4'b0110, 0);
        st("t2_drain_b1",    0, 1, LOAD, 0, 0, 0, 1, 0, 4'b0101, 0);
        st("t2_drain",       0, 1, LOAD, 0, 0, 0, 0, 0, 4'b0101, 0);
        st("t2_drain_b2",    0, 1, LOAD, 0, 0, 0, 1, 0, 4'b0101, 0);
        st("t2_drain_empty", 0, 1, LOAD, 0, 0, 0, 0, 0, 4'b0101, 0);
        st("t2_issue",       0, 1, LOAD, 1, 1, 0, 0, 0, 4'b1101, 0);
        st("t2_resp_r",      0, 0, 0,    0, 0, 0, 0, 1, 4'b0001, 0);
        st("t2_resp_b",      0, 0, 0,    0, 0, 0, 1, 0, 4'b0001, 0);
        st("t2_idle",        0, 0, 0,    0, 0, 0, 0, 0, 4'b1110, 1);
        // store ATOP: no R needed; AR held during RESP
        st("t3_atop_idle", 0, 1, STORE, 0, 0, 0, 0, 0, 4'b0110, 1);
        st("t3_drain",     0, 1, STORE, 0, 0, 0, 0, 0, 4'b0101, 1);
        st("t3_issue",     0, 1, STORE, 0, 0, 0, 0, 0, 4'b1101, 1);
        st("t3_resp_w_ar", 0, 0, 0,     1, 1, 1, 0, 0, 4'b0101, 1);
        st("t3_resp_b_ar", 0, 0, 0,     0, 0, 1, 1, 0, 4'b0001, 1);
        st("t3_ar_fwd",    0, 0, 0,     0, 0, 1, 0, 0, 4'b1110, 2);
        st("t3_rlast",     0, 0, 0,     0, 0, 0, 0, 1, 4'b1110, 2);
        // CntWidth=2 read saturation on dut1
        st("t4_ar1", 1, 0, 0, 0, 0, 1, 0, 0, 4'b1110, 2);
        st("t4_ar2", 1, 0, 0, 0, 0, 1, 0, 0, 4'b1110, 2);
        st("t4_ar3", 1, 0, 0, 0, 0, 1, 0, 0, 4'b1110, 2);
        drv(0, 0, 0, 0, 1, 0, 0);
        ch("t4_ar4_blocked", 1, 4'b1100, 2);
        ch("t4_ar4_wide",    0, 4'b1110, 2);
        tick();
        st("t4_rlast_full", 1, 0, 0, 0, 0, 0, 0, 1, 4'b1100, 2);
        st("t4_ar_and_rl",  1, 0, 0, 0, 0, 1, 0, 1, 4'b1110, 2);
        st("t4_ar_fill",    1, 0, 0, 0, 0, 1, 0, 0, 4'b1110, 2);
        st("t4_ar_blk2",    1, 0, 0, 0, 0, 1, 0, 0, 4'b1100, 2);
        // reset, then reset again in the middle of RESP
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        ch("t5_rst_d0", 0, 4'b1110, 0);
        ch("t5_rst_d1", 1, 4'b1110, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        st("t5_atop",  0, 1, SWAP, 0, 0, 0, 0, 0, 4'b0110, 0);
        st("t5_drain", 0, 1, SWAP, 0, 0, 0, 0, 0, 4'b0101, 0);
        st("t5_issue", 0, 1, SWAP, 1, 1, 0, 0, 0, 4'b1101, 0);
        st("t5_resp",  0, 0, 0,    0, 0, 0, 0, 0, 4'b0001, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        ch("t5_rst_resp_d0", 0, 4'b1110, 0);
        ch("t5_rst_resp_d1", 1, 4'b1110, 0);
        tick();
        rst_ni = 1'b1;
        st("t5_post_traffic", 0, 1, 0,     1, 1, 1, 0, 0, 4'b1110, 0);
        st("t5_post_resp",    0, 0, 0,     0, 0, 0, 1, 1, 4'b1110, 0);
        st("t5_floor_idle",   0, 1, STORE, 0, 0, 0, 0, 0, 4'b0110, 0);
        st("t5_floor_drain",  0, 1, STORE, 0, 0, 0, 0, 0, 4'b0101, 0);
        st("t5_floor_issue",  0, 1, STORE, 1, 1, 0, 0, 0, 4'b1101, 0);
        st("t5_floor_resp",   0, 0, 0,     0, 0, 0, 1, 0, 4'b0001, 0);
        st("t5_floor_done",   0, 0, 0,     0, 0, 0, 0, 0, 4'b1110, 1);
        tick();
        tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
